coefficient_controller: RTL
===========================

# coefficient_controller

Sequencing FSM for the linear-regression coefficient datapath that accumulates Σx, Σy, Σxy and Σx², computes the means, and then computes B1 and B0. The controller accepts a start request and pulls exactly NSAMPLES (x, y) pairs through a valid/request handshake. It drives every clear, load and counter-control strobe of the datapath, then reports completion with a one-cycle done pulse. It sits between the top-level stimulus/host logic and the datapath and owns no arithmetic.

## Interface
- NSAMPLES, 150, number of (x, y) pairs per run; legal range 1..255 (bounded by the datapath's 8-bit n).
- CNTW, 8, width of the internal sample counter.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-low: state is forced to IDLE while rst=0, independent of clk.
- start  in  1  run request; level-sampled.
- data_valid  in  1  the host presents a valid x/y pair on the datapath inputs this cycle.
- ready  out  1  controller is idle and will honour start.
- busy  out  1  a run is in progress (any state other than IDLE).
- data_req  out  1  controller is waiting for a sample.
- ld0xy, ld0x2, ld0x, ld0y  out  1 each  synchronous clear of the four accumulators.
- ldxy, ldx2, ldx, ldy  out  1 each  accumulate enable of the four accumulators.
- ldxbar, ldybar  out  1 each  load the mean registers.
- ldB1, ldB0  out  1 each  load the coefficient registers.
- ld1cnt  out  1  sets datapath n to 1.
- inccnt  out  1  increments datapath n.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, HOLD, CLEAR, SAMPLE, MEAN, COEF, DONE. The state register and the sample counter k (CNTW bits) are the only storage.
- IDLE
  - ready=1.
  - start=1 → HOLD.
- HOLD
  - Waits for start to return to 0, then → CLEAR. This makes one long start level produce exactly one run.
- CLEAR (one cycle)
  - Asserts ld0xy, ld0x2, ld0x, ld0y and ld1cnt.
  - k ← 0.
  - → SAMPLE.
- SAMPLE
  - data_req=1.
  - A sample is accepted in any cycle with data_valid=1. In that same cycle the controller asserts ldxy, ldx2, ldx and ldy combinationally from data_valid (Mealy outputs).
  - Accept with k < NSAMPLES-1: assert inccnt, k ← k+1, stay in SAMPLE.
  - Accept with k = NSAMPLES-1: no inccnt, → MEAN. Datapath n then equals NSAMPLES.
  - data_valid=0: all strobes low, no state change. Wait cycles between samples are unbounded.
- MEAN (one cycle)
  - Asserts ldxbar and ldybar.
  - → COEF.
- COEF (one cycle)
  - Asserts ldB1 and ldB0.
  - → DONE.
- DONE (one cycle)
  - done=1.
  - → IDLE.
- All outputs other than the SAMPLE-state accumulate strobes are Moore, decoded from state only. Every strobe is low in any state where it is not listed above.
- Invariant: the datapath's n equals the number of samples accepted so far, counting the sample currently being accepted.
- Ignored inputs:
  - start is ignored in every state except IDLE. It is not queued.
  - data_valid is ignored in every state except SAMPLE. Outside SAMPLE it produces no strobes.
- NSAMPLES=1: the first accept goes straight to MEAN, and inccnt is never asserted.

## Timing
- Reset values: state IDLE, k=0. ready=1, busy=0, all other outputs 0.
- Reset mid-run:
  - Asserting rst in any state clears the state and k immediately. Strobes drop asynchronously.
  - Partial accumulator contents are left as-is; the next run's CLEAR cleans them up.
  - After rst deasserts, a new start is required.
- Start to first data_req: start high at edge t0 → HOLD. Start low seen at edge t1 → CLEAR during (t1, t1+1). SAMPLE with data_req=1 from edge t1+1.
- Best-case run with data_valid held high: HOLD(≥1) + CLEAR(1) + NSAMPLES + MEAN(1) + COEF(1) + DONE(1) cycles.
- done rises exactly 3 cycles after the cycle that accepted the last sample.
- data_req is a level, not a pulse. x and y must be stable throughout the accepting cycle.
- k never wraps. Terminal detection compares against NSAMPLES-1, so CNTW only needs to hold NSAMPLES-1.

## Test plan
- Reset: hold rst=0 for 3 cycles with start=1 and data_valid=1 → ready=1, busy=0, every strobe 0. Release rst with start=0 → stays in IDLE.
- Nominal run: NSAMPLES=4, start high for 5 cycles, then data_valid always high, x=1,2,3,4 and y=2,4,6,8.
  - Exactly 1 CLEAR cycle with ld1cnt.
  - ldx/ldy/ldxy/ldx2 high for exactly 4 cycles.
  - inccnt high for 3 cycles; datapath n ends at 4.
  - Then ldxbar/ldybar for 1 cycle, ldB1/ldB0 for 1 cycle, done for 1 cycle, then ready=1.
- Gapped data: NSAMPLES=4, with data_valid low for 2 cycles between each pair → still exactly 4 accepts. No strobe is asserted during the gaps, and done comes 3 cycles after the 4th accept.
- Spurious inputs:
  - start pulsed during SAMPLE → no effect on the run, and no second run after DONE.
  - data_valid pulsed in IDLE/MEAN/COEF → no accumulate strobe.
- Reset mid-run: assert rst after the 2nd accept → immediate IDLE. A following start produces a fresh CLEAR and a full 4-sample run with correct strobe counts.
- Edge size: NSAMPLES=1 → one accept, zero inccnt, then MEAN/COEF/DONE. With NSAMPLES=255, inccnt count = 254.

Source files
------------

// File: rtl/coefficient_controller.sv
// Sequencing FSM for the regression coefficient datapath: clears the accumulators,
// pulls NSAMPLES (x, y) pairs, then loads the means and the coefficients, and pulses done.
module coefficient_controller #(
  parameter int unsigned NSAMPLES = 150,
  parameter int unsigned CNTW     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic data_valid,
  output logic ready,
  output logic busy,
  output logic data_req,
  output logic ld0xy,
  output logic ld0x2,
  output logic ld0x,
  output logic ld0y,
  output logic ldxy,
  output logic ldx2,
  output logic ldx,
  output logic ldy,
  output logic ldxbar,
  output logic ldybar,
  output logic ldB1,
  output logic ldB0,
  output logic ld1cnt,
  output logic inccnt,
  output logic done
);

  typedef enum logic [2:0] {
    IDLE, HOLD, CLEAR, SAMPLE, MEAN, COEF, DONE
  } state_t;

  localparam logic [CNTW-1:0] KLAST = CNTW'(NSAMPLES - 1);

  state_t          state_q, state_d;
  logic [CNTW-1:0] k_q, k_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    ready    = 1'b0;
    busy     = (state_q != IDLE);
    data_req = 1'b0;
    ld0xy    = 1'b0;
    ld0x2    = 1'b0;
    ld0x     = 1'b0;
    ld0y     = 1'b0;
    ldxy     = 1'b0;
    ldx2     = 1'b0;
    ldx      = 1'b0;
    ldy      = 1'b0;
    ldxbar   = 1'b0;
    ldybar   = 1'b0;
    ldB1     = 1'b0;
    ldB0     = 1'b0;
    ld1cnt   = 1'b0;
    inccnt   = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = HOLD;
      end
      HOLD: begin
        if (!start) state_d = CLEAR;
      end
      CLEAR: begin
        ld0xy   = 1'b1;
        ld0x2   = 1'b1;
        ld0x    = 1'b1;
        ld0y    = 1'b1;
        ld1cnt  = 1'b1;
        k_d     = '0;
        state_d = SAMPLE;
      end
      SAMPLE: begin
        data_req = 1'b1;
        // Accumulate strobes follow data_valid in the same cycle (Mealy);
        // n was preset to 1 in CLEAR, so only non-final accepts bump it.
        if (data_valid) begin
          ldxy = 1'b1;
          ldx2 = 1'b1;
          ldx  = 1'b1;
          ldy  = 1'b1;
          if (k_q == KLAST) begin
            state_d = MEAN;
          end else begin
            inccnt = 1'b1;
            k_d    = k_q + CNTW'(1);
          end
        end
      end
      MEAN: begin
        ldxbar  = 1'b1;
        ldybar  = 1'b1;
        state_d = COEF;
      end
      COEF: begin
        ldB1    = 1'b1;
        ldB0    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
